// File: rtl/rr_arbiter_1of8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant, BCD winner index,
// per-ownership hold limit and a one-cycle gap between consecutive grants.
module rr_arbiter_1of8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  output logic [7:0] gnt,
  output logic [3:0] gnt_bcd,
  output logic       gnt_valid,
  output logic       timeout_pulse
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [2:0]         ptr_r, ptr_s;
  logic [2:0]         owner_r, owner_s;
  logic [CNT_W-1:0]   hold_cnt_r, hold_cnt_s;
  logic [7:0]         gnt_r, gnt_s;
  logic [3:0]         gnt_bcd_r, gnt_bcd_s;
  logic               gnt_valid_r, gnt_valid_s;
  logic               timeout_r, timeout_s;
  logic [7:0]         eff_s;
  logic [3:0]         pick_s;

  // Returns {found, index} of the first set bit scanning start, start+1, ... with wrap.
  // Scanning from the farthest offset down lets the nearest candidate win last.
  function automatic logic [3:0] pick_winner(input logic [7:0] eff, input logic [2:0] start);
    logic [3:0] result;
    logic [2:0] idx;
    result = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (eff[idx]) begin
        result = {1'b1, idx};
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  assign eff_s  = req & ~mask;
  assign pick_s = pick_winner(eff_s, ptr_r);

  // Next-state and next-output computation for the three-state arbitration FSM.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    owner_s     = owner_r;
    hold_cnt_s  = hold_cnt_r;
    gnt_s       = gnt_r;
    gnt_bcd_s   = gnt_bcd_r;
    gnt_valid_s = gnt_valid_r;
    timeout_s   = 1'b0;
    case (state_r)
      IDLE, GAP: begin
        if (en && pick_s[3]) begin
          state_s     = GRANT;
          owner_s     = pick_s[2:0];
          hold_cnt_s  = CNT_W'(1);
          gnt_s       = 8'b0000_0001 << pick_s[2:0];
          gnt_bcd_s   = {1'b0, pick_s[2:0]};
          gnt_valid_s = 1'b1;
        end else begin
          state_s     = IDLE;
          hold_cnt_s  = {CNT_W{1'b0}};
          gnt_s       = 8'h00;
          gnt_bcd_s   = 4'h0;
          gnt_valid_s = 1'b0;
        end
      end
      GRANT: begin
        if (!eff_s[owner_r] || (hold_cnt_r == CNT_W'(MAX_HOLD))) begin
          // A drop takes precedence, so timeout only fires while the owner still requests.
          timeout_s   = eff_s[owner_r];
          state_s     = GAP;
          ptr_s       = owner_r + 3'd1;
          hold_cnt_s  = {CNT_W{1'b0}};
          gnt_s       = 8'h00;
          gnt_bcd_s   = 4'h0;
          gnt_valid_s = 1'b0;
        end else begin
          hold_cnt_s = hold_cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s     = IDLE;
        ptr_s       = 3'd0;
        owner_s     = 3'd0;
        hold_cnt_s  = {CNT_W{1'b0}};
        gnt_s       = 8'h00;
        gnt_bcd_s   = 4'h0;
        gnt_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      ptr_r       <= 3'd0;
      owner_r     <= 3'd0;
      hold_cnt_r  <= {CNT_W{1'b0}};
      gnt_r       <= 8'h00;
      gnt_bcd_r   <= 4'h0;
      gnt_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      owner_r     <= owner_s;
      hold_cnt_r  <= hold_cnt_s;
      gnt_r       <= gnt_s;
      gnt_bcd_r   <= gnt_bcd_s;
      gnt_valid_r <= gnt_valid_s;
      timeout_r   <= timeout_s;
    end
  end

  assign gnt           = gnt_r;
  assign gnt_bcd       = gnt_bcd_r;
  assign gnt_valid     = gnt_valid_r;
  assign timeout_pulse = timeout_r;

endmodule

// File: tb/tb_rr_arbiter_1of8.sv
// Directed bench for rr_arbiter_1of8 with MAX_HOLD=4; expected values are hand-computed.
module tb_rr_arbiter_1of8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] mask;
  logic [7:0] gnt;
  logic [3:0] gnt_bcd;
  logic       gnt_valid;
  logic       timeout_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  rr_arbiter_1of8 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .req           (req),
    .mask          (mask),
    .gnt           (gnt),
    .gnt_bcd       (gnt_bcd),
    .gnt_valid     (gnt_valid),
    .timeout_pulse (timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares {timeout_pulse, gnt_valid, gnt_bcd, gnt} against the expected bundle.
  task automatic check(input string tag, input logic [7:0] e_gnt, input logic [3:0] e_bcd,
                       input logic e_valid, input logic e_to);
    logic [13:0] obs;
    logic [13:0] exp_v;
    obs   = {timeout_pulse, gnt_valid, gnt_bcd, gnt};
    exp_v = {e_to, e_valid, e_bcd, e_gnt};
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed to/valid/bcd/gnt=%b/%b/%h/%h expected %b/%b/%h/%h",
             tag, obs[13], obs[12], obs[11:8], obs[7:0],
             exp_v[13], exp_v[12], exp_v[11:8], exp_v[7:0]);
    end
  endtask

  initial begin
    logic [2:0] own;
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;
    mask  = 8'h00;
    tick();
    check("reset", 8'h00, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic grant and release to requester 0; ptr moves to 1.
    en  = 1'b1;
    req = 8'h01;
    tick();
    check("t1_grant0", 8'h01, 4'h0, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    check("t1_release", 8'h00, 4'h0, 1'b0, 1'b0);

    // From ptr=1, requester 7 beats 0; then wrap back to 0 after a zero cycle.
    req = 8'h81;
    tick();
    check("t2_grant7", 8'h80, 4'h7, 1'b1, 1'b0);
    req = 8'h01;
    tick();
    check("t2_gap", 8'h00, 4'h0, 1'b0, 1'b0);
    tick();
    check("t2_wrap0", 8'h01, 4'h0, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    check("t2_release", 8'h00, 4'h0, 1'b0, 1'b0);
    tick();
    check("t2_idle", 8'h00, 4'h0, 1'b0, 1'b0);

    // All requesting: each owner holds 4 cycles, then timeout pulse during the gap.
    req = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      own = 3'(k + 1);
      for (int h = 0; h < 4; h++) begin
        tick();
        check($sformatf("t3_hold_o%0d_c%0d", own, h), 8'h01 << own, {1'b0, own}, 1'b1, 1'b0);
      end
      tick();
      check($sformatf("t3_timeout_o%0d", own), 8'h00, 4'h0, 1'b0, 1'b1);
    end
    req = 8'h00;
    tick();
    check("t3_idle", 8'h00, 4'h0, 1'b0, 1'b0);

    // Masked requester 2 is ignored; masking the owner releases without timeout.
    req  = 8'h24;
    mask = 8'h04;
    tick();
    check("t4_grant5", 8'h20, 4'h5, 1'b1, 1'b0);
    tick();
    check("t4_hold5", 8'h20, 4'h5, 1'b1, 1'b0);
    mask = 8'h24;
    tick();
    check("t4_mask_release", 8'h00, 4'h0, 1'b0, 1'b0);
    req  = 8'h00;
    mask = 8'h00;
    tick();
    check("t4_idle", 8'h00, 4'h0, 1'b0, 1'b0);

    // en low blocks new grants; en dropping during a grant does not preempt.
    en  = 1'b0;
    req = 8'h10;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("t5_blocked_c%0d", c), 8'h00, 4'h0, 1'b0, 1'b0);
    end
    en  = 1'b1;
    req = 8'h04;
    tick();
    check("t5_grant2", 8'h04, 4'h2, 1'b1, 1'b0);
    en = 1'b0;
    tick();
    check("t5_hold2_a", 8'h04, 4'h2, 1'b1, 1'b0);
    tick();
    check("t5_hold2_b", 8'h04, 4'h2, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    check("t5_release", 8'h00, 4'h0, 1'b0, 1'b0);
    tick();
    check("t5_idle", 8'h00, 4'h0, 1'b0, 1'b0);

    // Async reset mid-grant clears outputs at once and returns ptr to 0.
    en  = 1'b1;
    req = 8'h10;
    tick();
    check("t6_grant4", 8'h10, 4'h4, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_reset", 8'h00, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 8'h81;
    tick();
    check("t6_ptr0", 8'h01, 4'h0, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    check("t6_release", 8'h00, 4'h0, 1'b0, 1'b0);
    tick();
    req = 8'h08;
    tick();
    check("t6_grant3", 8'h08, 4'h3, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    check("t6_final_release", 8'h00, 4'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_1of8.md
Name: rr_arbiter_1of8

Overview:
Round-robin arbiter that shares one downstream resource between 8 requesters. It issues a registered one-hot grant plus the matching 4-bit BCD index of the winner. Each grant is held while the owner keeps requesting, up to a configurable hold limit. It sits in front of the shared datapath; gnt_bcd drives the resource's select/mux input, and gnt drives the per-requester acknowledge lines.

Parameters:
MAX_HOLD, 16, maximum consecutive grant cycles per ownership; legal range 1..2^CNT_W-1
CNT_W, 8, width of the internal hold counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  arbitration enable; low blocks new grants only
req  input  8  request lines, bit i = requester i, level-held
mask  input  8  per-requester disable, 1 = request ignored
gnt  output  8  one-hot grant, all zero when no owner
gnt_bcd  output  4  BCD index of the owner (0..7, bit3 always 0); 0 when no owner
gnt_valid  output  1  high while any grant is active
timeout_pulse  output  1  single-cycle pulse when a grant ends by hitting MAX_HOLD

Behaviour:
- Reset (async, immediate, also mid-grant): gnt=0, gnt_bcd=0, gnt_valid=0, timeout_pulse=0, ptr=0, hold_cnt=0, state=IDLE.
- Effective requests: eff = req & ~mask.
- All outputs are registered. Invariants:
  - gnt is zero or exactly one-hot.
  - gnt_bcd equals the index of the set gnt bit.
  - gnt_valid equals |gnt.
- State IDLE, on a rising edge with en=1 and eff!=0:
  - Winner = first set bit of eff scanning ptr, ptr+1, ... with wrap 7->0.
  - gnt, gnt_bcd and gnt_valid update at that edge. Latency is one edge from the first sampled request.
  - hold_cnt=1, state goes to GRANT.
- State GRANT, on each rising edge:
  - If eff[owner]=0 (request dropped or masked): release.
  - Else if hold_cnt==MAX_HOLD: release with timeout. timeout_pulse=1 for exactly that one cycle.
  - Else hold_cnt++ and the grant is unchanged.
- Release edge: gnt=0, gnt_bcd=0, gnt_valid=0, ptr=(owner+1) mod 8, hold_cnt=0, state goes to GAP.
- State GAP: exactly one dead cycle with all grants zero. The next edge arbitrates exactly as in IDLE. If en=0 or eff=0 on that edge, state goes to IDLE.
  - Minimum spacing between consecutive grants is therefore one zero cycle.
- en=0 during GRANT does not preempt. The grant continues until a normal release, and no new grant is issued while en=0.
- A requester that timed out and still holds req is eligible again, but only after the other requesters, because ptr has moved past it.
- Simultaneous drop of req[owner] and hold_cnt==MAX_HOLD: treated as a normal release, timeout_pulse=0.
- Mask change during GRANT that masks the owner is treated as a drop. Unmasking only affects future arbitration.
- req/mask changes for non-owners during GRANT have no effect until the next arbitration edge.

Test Plan:
- Reset, then req=8'h01, en=1, mask=0 -> one edge later gnt=8'h01, gnt_bcd=4'h0, gnt_valid=1. Drop req -> next edge gnt=0; ptr=1 (checked via the next test).
- req=8'h81 held, ptr=1 -> winner 7: gnt=8'h80, gnt_bcd=4'h7. Drop req[7] -> one zero cycle, then gnt=8'h01, gnt_bcd=4'h0 (wrap-around fairness).
- req=8'hFF held continuously, MAX_HOLD=4 -> each of gnt_bcd 0,1,...,7 owns 4 cycles in turn. There is one zero cycle between owners and a one-cycle timeout_pulse at each release.
- req=8'h24, mask=8'h04 -> only requester 5 granted (gnt=8'h20, gnt_bcd=4'h5). Set mask[5]=1 mid-grant -> release next edge, timeout_pulse=0.
- en=0 with req=8'h10 -> gnt stays 0 indefinitely. Raise en during an active grant to requester 2, then drop en -> grant to requester 2 persists until req[2] falls.
- Assert rst_n=0 asynchronously mid-grant (between clock edges) -> gnt, gnt_bcd, gnt_valid and timeout_pulse go to 0 immediately. After release, req=8'h08 -> gnt_bcd=4'h3 (ptr back at 0).
